// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stop polarity,
// per-requester stall vectors and FSM state encoding.
package pipe_ctrl_pkg;

    // Per-stage hold polarity on the stall vector.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vectors, bit0 PC ... bit5 WB. The stage after the requester is left
    // running so it drains into a bubble.
    localparam logic [5:0] StallNone = {6{NO_STOP}};
    localparam logic [5:0] StallIf   = {{4{NO_STOP}}, {2{STOP}}};
    localparam logic [5:0] StallId   = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [5:0] StallEx   = {{2{NO_STOP}}, {4{STOP}}};
    localparam logic [5:0] StallMem  = {NO_STOP, {5{STOP}}};
    localparam logic [5:0] StallAll  = {6{STOP}};

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StHold   = 2'd1,
        StFreeze = 2'd2,
        StFlush  = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// stall_encoder: priority encoder from the four stall requests to the stall
// vector; the deepest requesting stage wins.
module stall_encoder
    import pipe_ctrl_pkg::*;
(
    input  logic       i_req_if,
    input  logic       i_req_id,
    input  logic       i_req_ex,
    input  logic       i_req_mem,
    output logic [5:0] o_stall
);

    // Deepest stage first so a later hazard freezes everything upstream of it.
    always_comb begin
        o_stall = StallNone;
        if (i_req_mem) begin
            o_stall = StallMem;
        end else if (i_req_ex) begin
            o_stall = StallEx;
        end else if (i_req_id) begin
            o_stall = StallId;
        end else if (i_req_if) begin
            o_stall = StallIf;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with a stall watchdog.
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero and no counter flops exist.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] EXCP_VECTOR    = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout_err,
    output logic [31:0] stall_cycles
);

    localparam logic [15:0] HoldLimit = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    logic [15:0] r_hold_cnt;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic        r_timeout_err;

    logic [5:0]  w_enc_stall;
    logic        w_any_req;

    assign w_any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

    stall_encoder u_stall_encoder (
        .i_req_if  (stallreq_if),
        .i_req_id  (stallreq_id),
        .i_req_ex  (stallreq_ex),
        .i_req_mem (stallreq_mem),
        .o_stall   (w_enc_stall)
    );

    // Stall vector: live from requests in RUN/HOLD, full freeze on exception.
    always_comb begin
        stall = StallNone;
        if (!rst) begin
            unique case (r_state)
                StRun, StHold: stall = excp_req ? StallAll : w_enc_stall;
                StFreeze:      stall = StallAll;
                StFlush:       stall = StallNone;
                default:       stall = StallNone;
            endcase
        end
    end

    // Control FSM with registered flush/new_pc/watchdog outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StRun;
            r_hold_cnt    <= '0;
            r_flush       <= 1'b0;
            r_new_pc      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_flush  <= 1'b0;
            r_new_pc <= '0;
            unique case (r_state)
                StRun: begin
                    r_hold_cnt <= '0;
                    if (excp_req) begin
                        r_state <= StFreeze;
                    end else if (w_any_req) begin
                        r_state <= StHold;
                    end
                end
                StHold: begin
                    // Exception outranks both release and the watchdog.
                    if (excp_req) begin
                        r_state    <= StFreeze;
                        r_hold_cnt <= '0;
                    end else if (!w_any_req) begin
                        r_state    <= StRun;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HoldLimit) begin
                        r_state       <= StFreeze;
                        r_hold_cnt    <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                StFreeze: begin
                    // Flush goes out registered alongside the FLUSH state.
                    r_state  <= StFlush;
                    r_flush  <= 1'b1;
                    r_new_pc <= EXCP_VECTOR;
                end
                StFlush: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    assign flush       = r_flush;
    assign new_pc      = r_new_pc;
    assign timeout_err = r_timeout_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;

    // Count cycles with the PC held, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall[0] == STOP && r_stall_cycles != 32'hFFFF_FFFF) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_IF   = 4'b0001;
    localparam logic [3:0] R_ID   = 4'b0010;
    localparam logic [3:0] R_EX   = 4'b0100;
    localparam logic [3:0] R_MEM  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        excp_req = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        timeout_err;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]  q_stall[$];
    logic        q_flush[$];
    logic        q_to[$];
    logic [31:0] q_sc[$];
    string       q_name[$];
    logic [31:0] model_sc = 32'd0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .TIMEOUT_CYCLES (8),
        .EXCP_VECTOR    (32'h0000_0020)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_req     (excp_req),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .timeout_err  (timeout_err),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus its expected response.
    task automatic step(input logic r, input logic [3:0] req, input logic e,
                        input logic [5:0] es, input logic ef, input logic eto,
                        input string nm);
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_if  = req[0];
        stallreq_id  = req[1];
        stallreq_ex  = req[2];
        stallreq_mem = req[3];
        excp_req     = e;
        q_stall.push_back(es);
        q_flush.push_back(ef);
        q_to.push_back(eto);
        q_name.push_back(nm);
`ifdef PIPE_CTRL_PERF_EN
        q_sc.push_back(model_sc);
        if (r) model_sc = 32'd0;
        else if (es[0] && model_sc != 32'hFFFF_FFFF) model_sc = model_sc + 32'd1;
`else
        q_sc.push_back(32'd0);
`endif
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (q_stall.size() > 0) begin
            logic [5:0]  es;
            logic        ef;
            logic        eto;
            logic [31:0] esc;
            string       nm;
            es  = q_stall.pop_front();
            ef  = q_flush.pop_front();
            eto = q_to.pop_front();
            esc = q_sc.pop_front();
            nm  = q_name.pop_front();
            chk({nm, ".stall"}, {26'd0, stall}, {26'd0, es});
            chk({nm, ".flush"}, {31'd0, flush}, {31'd0, ef});
            chk({nm, ".new_pc"}, new_pc, ef ? 32'h0000_0020 : 32'h0);
            chk({nm, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, eto});
            chk({nm, ".stall_cycles"}, stall_cycles, esc);
        end
    end

    initial begin
        // Reset state
        step(1, R_NONE, 0, 6'b000000, 0, 0, "rst0");
        step(1, R_NONE, 0, 6'b000000, 0, 0, "rst1");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "idle");

        // Load-use hazard for three cycles
        for (int i = 0; i < 3; i++) step(0, R_ID, 0, 6'b000111, 0, 0, "id3");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "id_release");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "id_after");

        // Priority between simultaneous requesters
        step(0, R_IF | R_MEM, 0, 6'b011111, 0, 0, "if_mem");
        step(0, R_EX, 0, 6'b001111, 0, 0, "ex");
        step(0, R_IF, 0, 6'b000011, 0, 0, "if");
        step(0, R_ID | R_EX, 0, 6'b001111, 0, 0, "id_ex");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "prio_release");

        // Exception pulse; inputs during FREEZE/FLUSH must be ignored
        step(0, R_NONE, 1, 6'b111111, 0, 0, "excp_n");
        step(0, R_MEM, 1, 6'b111111, 0, 0, "excp_freeze");
        step(0, R_EX, 0, 6'b000000, 1, 0, "excp_flush");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "excp_run");

        // Exception with concurrent EX stall: no HOLD entry
        step(0, R_EX, 1, 6'b111111, 0, 0, "excp_ex");
        step(0, R_EX, 0, 6'b111111, 0, 0, "excp_ex_freeze");
        step(0, R_EX, 0, 6'b000000, 1, 0, "excp_ex_flush");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "excp_ex_run");

        // Exception while already in HOLD
        step(0, R_ID, 0, 6'b000111, 0, 0, "hold_enter");
        step(0, R_ID, 1, 6'b111111, 0, 0, "hold_excp");
        step(0, R_ID, 0, 6'b111111, 0, 0, "hold_freeze");
        step(0, R_NONE, 0, 6'b000000, 1, 0, "hold_flush");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "hold_run");

        // Watchdog: MEM held, timeout 8
        step(0, R_MEM, 0, 6'b011111, 0, 0, "wd_run");
        for (int i = 0; i < 8; i++) step(0, R_MEM, 0, 6'b011111, 0, 0, "wd_hold");
        step(0, R_MEM, 0, 6'b111111, 0, 1, "wd_freeze");
        step(0, R_MEM, 0, 6'b000000, 1, 1, "wd_flush");
        step(0, R_NONE, 0, 6'b000000, 0, 1, "wd_run2");
        step(0, R_IF, 0, 6'b000011, 0, 1, "wd_sticky");
        step(0, R_NONE, 0, 6'b000000, 0, 1, "wd_sticky2");

        // Reset in FREEZE: no flush, everything cleared
        step(0, R_NONE, 1, 6'b111111, 0, 1, "rstf_excp");
        step(1, R_NONE, 0, 6'b000000, 0, 1, "rstf_rst");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "rstf_after");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "rstf_after2");

        // Reset mid-HOLD
        step(0, R_ID, 0, 6'b000111, 0, 0, "rsth_hold");
        step(1, R_ID, 0, 6'b000000, 0, 0, "rsth_rst");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "rsth_after");
        step(0, R_EX, 0, 6'b001111, 0, 0, "rsth_ex");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "rsth_release");
        step(0, R_NONE, 0, 6'b000000, 0, 0, "final");

        repeat (2) @(negedge clk);
        chk("drain", q_stall.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max consecutive stall cycles before watchdog fires.
REQ-002 SHALL have parameter EXCP_VECTOR, default 32'h0000_0020, PC driven on flush.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port stallreq_if  in  1  fetch bus wait.
REQ-005 SHALL have port stallreq_id  in  1  load-use hazard.
REQ-006 SHALL have port stallreq_ex  in  1  multi-cycle EX op busy.
REQ-007 SHALL have port stallreq_mem  in  1  data bus wait.
REQ-008 SHALL have port excp_req  in  1  exception raised in MEM.
REQ-009 SHALL have port stall  out  6  per-stage hold; bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB; 1=STOP.
REQ-010 SHALL have port flush  out  1  clear all pipeline registers.
REQ-011 SHALL have port new_pc  out  32  redirect PC, valid when flush=1.
REQ-012 SHALL have port timeout_err  out  1  sticky watchdog flag.
REQ-013 SHALL have port stall_cycles  out  32  stall statistics counter.

Function
REQ-014 SHALL implement FSM states RUN, HOLD, FREEZE, FLUSH.
REQ-015 In RUN/HOLD, stall SHALL be combinational from requests; deepest requester wins: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-016 The encoding SHALL leave the stage after the requester unstalled, so that stage inserts a bubble.
REQ-017 RUN->HOLD SHALL occur on any stallreq; HOLD->RUN SHALL occur in the first cycle with no stallreq.
REQ-018 A 16-bit hold counter SHALL increment each cycle in HOLD and clear on leaving HOLD.
REQ-019 When the hold counter reaches TIMEOUT_CYCLES-1 with a request still present, the block SHALL set timeout_err and enter FREEZE.
REQ-020 excp_req in RUN or HOLD SHALL enter FREEZE.
REQ-021 excp_req SHALL take priority over stall requests and over the watchdog in the same cycle.
REQ-022 In the cycle excp_req is sampled, stall SHALL be 6'b111111 combinationally.
REQ-023 FREEZE SHALL last exactly one cycle with stall=6'b111111, then go to FLUSH.
REQ-024 In FLUSH, flush=1, new_pc=EXCP_VECTOR and stall=6'b000000 for exactly one cycle, then RUN.
REQ-025 flush SHALL be registered; latency from excp_req to flush is 2 cycles.
REQ-026 stallreq_* and excp_req SHALL be ignored in FREEZE and FLUSH.
REQ-027 new_pc SHALL be 32'h0 whenever flush=0.
REQ-028 timeout_err SHALL be cleared only by rst.

Reset
REQ-029 rst SHALL force state RUN, hold counter 0, flush 0, new_pc 0, timeout_err 0 and stall_cycles 0.
REQ-030 While rst=1, stall SHALL be 6'b000000.
REQ-031 rst mid-HOLD or mid-FLUSH SHALL abort the sequence with no residual flush pulse.

Configuration
REQ-032 With macro PIPE_CTRL_PERF_EN defined, stall_cycles SHALL increment by 1 each cycle in which stall[0]=1, saturating at 32'hFFFF_FFFF.
REQ-033 Without PIPE_CTRL_PERF_EN, stall_cycles SHALL be constant 0 and no counter flops SHALL be generated.

Structure
REQ-034 A shared package SHALL hold STOP/NO_STOP values, the five stall-vector constants and the FSM state encoding.
REQ-035 The priority encoder SHALL be a sub-module stall_encoder (4 requests in, 6-bit vector out), instantiated once.

Verification
REQ-036 stallreq_id=1 for 3 cycles -> stall=6'b000111 for those 3 cycles, then 6'b000000; stall_cycles=3 (PERF_EN).
REQ-037 stallreq_if=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111.
REQ-038 excp_req pulse at cycle N -> stall=6'b111111 at N and N+1; flush=1 and new_pc=32'h20 at N+2; RUN at N+3.
REQ-039 excp_req together with stallreq_ex -> stall=6'b111111 and no HOLD entry.
REQ-040 stallreq_mem held continuously, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 HOLD cycles, followed by one FREEZE cycle and one flush pulse; timeout_err stays 1 until rst.
REQ-041 rst asserted in FREEZE -> flush never asserts; all outputs are 0 on the next cycle.
